// File: rtl/updown_arb_pkg.sv
// Shared types and constants for the round-robin up/down counter arbiter.
package updown_arb_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT  = 2'b01,
      UPDATE = 2'b10
   } state_t;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 8;

   // Pointer width covers the largest supported requester count (8).
   localparam int PTR_W = 3;

   // Convert a one-hot vector (up to 8 bits) to its bit index.
   function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [7:0] onehot);
      logic [PTR_W-1:0] idx;
      idx = 3'b000;
      for (int i = 0; i < 8; i++) begin
         idx = idx | (onehot[i] ? 3'(i) : 3'b000);
      end
      return idx;
   endfunction

endpackage

// File: rtl/updown_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible request at or above ptr,
// wrapping around. Eligible means requested and not masked.
module rr_picker
   import updown_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   input  logic [N_REQ-1:0] mask,
   output logic [N_REQ-1:0] winner,
   output logic             valid
);

   logic [N_REQ-1:0]   eligible_s;
   logic [2*N_REQ-1:0] rot_dbl_s;
   logic [N_REQ-1:0]   rot_pick_s;
   logic [2*N_REQ-1:0] unrot_dbl_s;
   logic               found_s;

   // Rotate so the pointer position lands on bit 0.
   assign eligible_s = req & ~mask;
   assign rot_dbl_s  = {eligible_s, eligible_s} >> ptr;

   // Keep only the lowest set bit of the rotated vector.
   always_comb begin
      found_s    = 1'b0;
      rot_pick_s = {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         rot_pick_s[i] = rot_dbl_s[i] & ~found_s;
         found_s       = found_s | rot_dbl_s[i];
      end
   end

   // Rotate the single pick back into requester numbering.
   assign unrot_dbl_s = {rot_pick_s, rot_pick_s} << ptr;
   assign winner      = unrot_dbl_s[2*N_REQ-1:N_REQ];
   assign valid       = found_s;

endmodule

// File: rtl/updown_arbiter.sv
// Round-robin arbiter sharing one saturating up/down counter among N_REQ
// requesters. One grant at a time; each completed grant steps the count
// once and emits ack plus exactly one of inc/dec/sat.
module updown_arbiter
   import updown_arb_pkg::*;
#(
   parameter int          N_REQ   = DEF_N_REQ,
   parameter int          WIDTH   = DEF_WIDTH,
   parameter int unsigned MAX_VAL = 255,
   parameter int unsigned MIN_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] dir,
   output logic [N_REQ-1:0] gnt,
   output logic             ack,
   output logic [WIDTH-1:0] count,
   output logic             inc,
   output logic             dec,
   output logic             sat
);

   localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] MIN_C    = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [N_REQ-1:0] NO_REQ   = {N_REQ{1'b0}};
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

   state_t           state_r, state_nx;
   logic [PTR_W-1:0] ptr_r, ptr_nx;
   logic [N_REQ-1:0] gnt_r, gnt_nx;
   logic [WIDTH-1:0] count_r, count_nx;
   logic             ack_r, ack_nx;
   logic             inc_r, inc_nx;
   logic             dec_r, dec_nx;
   logic             sat_r, sat_nx;

   logic [N_REQ-1:0] pick_mask_s;
   logic [N_REQ-1:0] pick_win_s;
   logic             pick_valid_s;
   logic             win_held_s;
   logic             win_up_s;
   logic [PTR_W-1:0] win_idx_s;

   // The holder that just finished is excluded from the follow-on search.
   assign pick_mask_s = (state_r == UPDATE) ? gnt_r : NO_REQ;

   rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .req    (req),
      .ptr    (ptr_r),
      .mask   (pick_mask_s),
      .winner (pick_win_s),
      .valid  (pick_valid_s)
   );

   assign win_held_s = |(req & gnt_r);
   assign win_up_s   = |(dir & gnt_r);
   assign win_idx_s  = onehot_to_idx(8'(gnt_r));

   // Next-state, next-grant, count step and pulse decisions.
   always_comb begin
      state_nx = state_r;
      ptr_nx   = ptr_r;
      gnt_nx   = gnt_r;
      count_nx = count_r;
      ack_nx   = 1'b0;
      inc_nx   = 1'b0;
      dec_nx   = 1'b0;
      sat_nx   = 1'b0;
      case (state_r)
         IDLE: begin
            if (pick_valid_s) begin
               state_nx = GRANT;
               gnt_nx   = pick_win_s;
            end else begin
               state_nx = IDLE;
               gnt_nx   = NO_REQ;
            end
         end
         GRANT: begin
            if (win_held_s) begin
               state_nx = UPDATE;
               ack_nx   = 1'b1;
               ptr_nx   = (win_idx_s == LAST_IDX) ? {PTR_W{1'b0}} : (win_idx_s + 3'b001);
               if (win_up_s) begin
                  if (count_r < MAX_C) begin
                     count_nx = count_r + STEP_ONE;
                     inc_nx   = 1'b1;
                  end else begin
                     sat_nx   = 1'b1;
                  end
               end else begin
                  if (count_r > MIN_C) begin
                     count_nx = count_r - STEP_ONE;
                     dec_nx   = 1'b1;
                  end else begin
                     sat_nx   = 1'b1;
                  end
               end
            end else begin
               // Requester withdrew: abandon the grant, keep pointer and count.
               state_nx = IDLE;
               gnt_nx   = NO_REQ;
            end
         end
         UPDATE: begin
            if (pick_valid_s) begin
               state_nx = GRANT;
               gnt_nx   = pick_win_s;
            end else begin
               state_nx = IDLE;
               gnt_nx   = NO_REQ;
            end
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = NO_REQ;
         end
      endcase
   end

   // State, pointer, grant, count and pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         ptr_r   <= {PTR_W{1'b0}};
         gnt_r   <= NO_REQ;
         count_r <= MIN_C;
         ack_r   <= 1'b0;
         inc_r   <= 1'b0;
         dec_r   <= 1'b0;
         sat_r   <= 1'b0;
      end else begin
         state_r <= state_nx;
         ptr_r   <= ptr_nx;
         gnt_r   <= gnt_nx;
         count_r <= count_nx;
         ack_r   <= ack_nx;
         inc_r   <= inc_nx;
         dec_r   <= dec_nx;
         sat_r   <= sat_nx;
      end
   end

   assign gnt   = gnt_r;
   assign ack   = ack_r;
   assign count = count_r;
   assign inc   = inc_r;
   assign dec   = dec_r;
   assign sat   = sat_r;

endmodule

// File: tb/tb_updown_arbiter.sv
// Self-checking bench for updown_arbiter: a reference model pushes the
// expected result of every step; a monitor pops and compares on each ack.
module tb_updown_arbiter;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] dir;
   logic [3:0] gnt;
   logic       ack;
   logic [7:0] count;
   logic       inc;
   logic       dec;
   logic       sat;

   typedef struct packed {
      logic [3:0] gnt;
      logic [7:0] count;
      logic       inc;
      logic       dec;
      logic       sat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   count_m;
   int   ptr_m;

   always #5 clk = ~clk;

   updown_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .dir   (dir),
      .gnt   (gnt),
      .ack   (ack),
      .count (count),
      .inc   (inc),
      .dec   (dec),
      .sat   (sat)
   );

   // Scoreboard monitor: every ack must match the oldest expected step.
   always @(negedge clk) begin
      exp_t e;
      if (ack === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ack: got gnt=%b count=%0d inc=%b dec=%b sat=%b, required no ack",
                     gnt, count, inc, dec, sat);
         end else begin
            e = sb.pop_front();
            if ({gnt, count, inc, dec, sat} !== e) begin
               bad++;
               $display("FAIL step_result: got gnt=%b count=%0d inc=%b dec=%b sat=%b, required gnt=%b count=%0d inc=%b dec=%b sat=%b",
                        gnt, count, inc, dec, sat, e.gnt, e.count, e.inc, e.dec, e.sat);
            end
         end
      end else begin
         total++;
         if ({inc, dec, sat} !== 3'b000) begin
            bad++;
            $display("FAIL pulse_without_ack: got inc/dec/sat=%b, required 000", {inc, dec, sat});
         end
      end
   end

   // Reference model: n steps with request/direction vectors held.
   task automatic model_steps(input logic [3:0] rv, input logic [3:0] dv, input int n);
      for (int k = 0; k < n; k++) begin
         int   w;
         exp_t e;
         w = -1;
         for (int i = 0; i < N; i++) begin
            int j;
            j = (ptr_m + i) % N;
            if (w < 0 && rv[j] == 1'b1) w = j;
         end
         e.gnt = 4'b0001 << w;
         e.inc = 1'b0;
         e.dec = 1'b0;
         e.sat = 1'b0;
         if (dv[w] == 1'b1) begin
            if (count_m < 255) begin count_m++; e.inc = 1'b1; end
            else e.sat = 1'b1;
         end else begin
            if (count_m > 0) begin count_m--; e.dec = 1'b1; end
            else e.sat = 1'b1;
         end
         e.count = 8'(count_m);
         sb.push_back(e);
         ptr_m = (w + 1) % N;
      end
   endtask

   // Drive a held request pattern until n acks, then release it.
   task automatic run_steps(input logic [3:0] rv, input logic [3:0] dv, input int n);
      int seen;
      seen = 0;
      model_steps(rv, dv, n);
      @(negedge clk);
      req = rv;
      dir = dv;
      for (int c = 0; c < 8 * n + 8 && seen < n; c++) begin
         @(negedge clk);
         if (ack === 1'b1) seen++;
      end
      req = 4'b0000;
      @(negedge clk);
      total++;
      if (seen != n || sb.size() != 0) begin
         bad++;
         $display("FAIL run_steps_acks: got %0d acks (%0d pending), required %0d acks", seen, sb.size(), n);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = 4'b0000;
      dir   = 4'b0000;
      @(negedge clk);
      reset   = 1'b0;
      count_m = 0;
      ptr_m   = 0;
      sb.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = 4'b0000;
      dir   = 4'b0000;
      repeat (2) @(negedge clk);
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b, required 0000", gnt); end
      total++;
      if (count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d, required 0", count); end
      total++;
      if ({ack, inc, dec, sat} !== 4'b0000) begin
         bad++; $display("FAIL reset_pulses: got ack/inc/dec/sat=%b, required 0000", {ack, inc, dec, sat});
      end
      reset   = 1'b0;
      count_m = 0;
      ptr_m   = 0;
   endtask

   task automatic test_single_up();
      model_steps(4'b0001, 4'b0001, 1);
      @(negedge clk);
      req = 4'b0001;
      dir = 4'b0001;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0001 || ack !== 1'b0) begin
         bad++; $display("FAIL single_grant: got gnt=%b ack=%b, required gnt=0001 ack=0", gnt, ack);
      end
      @(negedge clk);
      total++;
      if (ack !== 1'b1 || inc !== 1'b1 || count !== 8'd1) begin
         bad++; $display("FAIL single_update: got ack=%b inc=%b count=%0d, required ack=1 inc=1 count=1", ack, inc, count);
      end
      req = 4'b0000;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0000 || ack !== 1'b0 || inc !== 1'b0 || count !== 8'd1) begin
         bad++; $display("FAIL single_idle: got gnt=%b ack=%b inc=%b count=%0d, required gnt=0000 ack=0 inc=0 count=1",
                         gnt, ack, inc, count);
      end
   endtask

   task automatic test_round_robin();
      int t[5];
      int seen;
      do_reset();
      model_steps(4'b1111, 4'b1111, 5);
      seen = 0;
      @(negedge clk);
      req = 4'b1111;
      dir = 4'b1111;
      for (int c = 0; c < 40 && seen < 5; c++) begin
         @(negedge clk);
         if (ack === 1'b1) begin
            t[seen] = c;
            seen++;
         end
      end
      req = 4'b0000;
      @(negedge clk);
      total++;
      if (seen != 5) begin bad++; $display("FAIL rr_ack_count: got %0d, required 5", seen); end
      total++;
      if (seen > 0 && t[0] != 1) begin bad++; $display("FAIL rr_first_latency: got cycle %0d, required 1", t[0]); end
      for (int i = 1; i < seen; i++) begin
         total++;
         if (t[i] - t[i-1] != 2) begin
            bad++; $display("FAIL rr_spacing: got %0d cycles, required 2", t[i] - t[i-1]);
         end
      end
      total++;
      if (count !== 8'd5 || gnt !== 4'b0000) begin
         bad++; $display("FAIL rr_final: got count=%0d gnt=%b, required count=5 gnt=0000", count, gnt);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      run_steps(4'b1111, 4'b1111, 256);
      total++;
      if (count !== 8'd255) begin bad++; $display("FAIL sat_max_count: got %0d, required 255", count); end
      do_reset();
      run_steps(4'b0100, 4'b0000, 1);
      total++;
      if (count !== 8'd0) begin bad++; $display("FAIL sat_min_count: got %0d, required 0", count); end
   endtask

   task automatic test_cancel();
      do_reset();
      run_steps(4'b0001, 4'b0001, 1);
      @(negedge clk);
      req = 4'b0100;
      dir = 4'b0100;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0100) begin bad++; $display("FAIL cancel_grant: got %b, required 0100", gnt); end
      req = 4'b0000;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0000 || ack !== 1'b0 || count !== 8'd1) begin
         bad++; $display("FAIL cancel_idle: got gnt=%b ack=%b count=%0d, required gnt=0000 ack=0 count=1", gnt, ack, count);
      end
      // Pointer must still be 1: requester 1 beats requester 0.
      run_steps(4'b0011, 4'b0011, 1);
   endtask

   task automatic test_mixed();
      do_reset();
      run_steps(4'b1111, 4'b1111, 4);
      run_steps(4'b1000, 4'b1000, 1);
      total++;
      if (count !== 8'd5) begin bad++; $display("FAIL mixed_setup: got %0d, required 5", count); end
      run_steps(4'b0011, 4'b0001, 2);
      total++;
      if (count !== 8'd5) begin bad++; $display("FAIL mixed_final: got %0d, required 5", count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      run_steps(4'b0010, 4'b0010, 3);
      @(negedge clk);
      req = 4'b0100;
      dir = 4'b0100;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0100) begin bad++; $display("FAIL areset_grant: got %b, required 0100", gnt); end
      #2 reset = 1'b1;
      #1;
      total++;
      if (gnt !== 4'b0000 || count !== 8'd0 || {ack, inc, dec, sat} !== 4'b0000) begin
         bad++; $display("FAIL areset_immediate: got gnt=%b count=%0d ack/inc/dec/sat=%b, required all zero",
                         gnt, count, {ack, inc, dec, sat});
      end
      @(negedge clk);
      total++;
      if (count !== 8'd0 || ack !== 1'b0) begin
         bad++; $display("FAIL areset_discard: got count=%0d ack=%b, required count=0 ack=0", count, ack);
      end
      req     = 4'b0000;
      reset   = 1'b0;
      count_m = 0;
      ptr_m   = 0;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL areset_idle: got %b, required 0000", gnt); end
      // Pointer back at 0: requester 1 wins over requester 2.
      run_steps(4'b0110, 4'b0110, 1);
   endtask

   initial begin
      test_reset();
      test_single_up();
      test_round_robin();
      test_saturation();
      test_cancel();
      test_mixed();
      test_async_reset();
      @(negedge clk);
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/updown_arbiter.md
# updown_arbiter

Round-robin scheduler that shares one saturating up/down counter among N_REQ requesters. Each requester posts an up or down request. The block grants one requester at a time and applies that requester's step to the shared count. It produces the same style of one-cycle inc/dec pulses as the up/down FSM it sequences, plus a saturation pulse when a step is blocked at a limit.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, counter width in bits
- MAX_VAL, 255, upper saturation limit (must be > MIN_VAL and < 2^WIDTH)
- MIN_VAL, 0, lower saturation limit and reset value of count

Ports:
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  N_REQ  per-requester request level
- dir  in  N_REQ  per-requester direction: 1 = up, 0 = down
- gnt  out  N_REQ  one-hot grant, registered
- ack  out  1  one-cycle completion pulse for the current gnt holder
- count  out  WIDTH  shared counter value, registered
- inc  out  1  one-cycle pulse: count incremented this transaction
- dec  out  1  one-cycle pulse: count decremented this transaction
- sat  out  1  one-cycle pulse: step blocked at MAX_VAL/MIN_VAL

## Operation
- States: IDLE, GRANT, UPDATE.
- IDLE: gnt=0. If any req is high at the edge, go to GRANT and register the winner in gnt.
- GRANT: gnt held. At the next edge:
  - Winner's req still high: go to UPDATE and apply the winner's dir step.
  - Winner's req low: cancel. Go to IDLE, no count change, no pulses, pointer unchanged.
- Step rules:
  - Up with count<MAX_VAL: count+1, inc=1.
  - Up with count==MAX_VAL: count unchanged, sat=1.
  - Down mirrors this against MIN_VAL and sets dec or sat.
  - Exactly one of inc/dec/sat is high in UPDATE.
- UPDATE:
  - gnt still held; ack=1 along with the inc/dec/sat pulse.
  - Round-robin pointer moves to (winner+1) mod N_REQ.
  - Next edge: if any req other than the winner's is high, go to GRANT with the new winner. Otherwise go to IDLE.
  - The winner's own req is masked in that cycle.
- Arbitration: the winner is the first asserted req searching upward from the pointer, with wrap-around. Pointer resets to 0.
- The requester must hold req and dir stable from assertion through GRANT. It drops req in the cycle after seeing ack, or re-asserts it later for another step.
- count never leaves [MIN_VAL, MAX_VAL]. No wrap-around.

## Timing
- Reset values: state=IDLE, gnt=0, ack=0, inc=dec=sat=0, count=MIN_VAL, pointer=0.
- Reset asserted mid-transaction takes effect immediately. A pending step is discarded and never applied.
- Latency, with req sampled at edge k:
  - gnt valid after edge k.
  - count, ack and pulse valid after edge k+1.
  - Pulses clear after edge k+2.
- Throughput: one step per 2 cycles under continuous contention. With a single requester holding req, one step per 3 cycles (UPDATE→IDLE→GRANT).
- dir is sampled at edge k+1 only.
- Simultaneous req arrival is resolved by the pointer only. There is no fixed priority.

## Structure
- Package updown_arb_pkg:
  - State encoding constants IDLE=2'b00, GRANT=2'b01, UPDATE=2'b10.
  - Default N_REQ/WIDTH values.
- Sub-module rr_picker: purely combinational. Inputs are the req vector, pointer and mask; outputs are the one-hot winner and a valid flag. Instantiated once.
- The top module holds the FSM, pointer, gnt register, count register and pulse registers.

## Test plan
- Reset/single up: reset, then req=0001, dir=0001 → gnt=0001 one cycle later. Next cycle count=1, inc=1, ack=1. Then IDLE.
- Round-robin fairness: req=1111 held with dir=1111, acked requesters re-asserting → grants 0001, 0010, 0100, 1000, 0001. count +1 per UPDATE, steps 2 cycles apart.
- Saturation: with defaults, drive count to 255, then request up → count stays 255, sat=1, inc=0. At count 0, a down request gives sat=1, dec=0.
- Cancel: req=0100 drops during GRANT → return to IDLE, count unchanged, no ack/pulses. Next grant still searches from the old pointer.
- Mixed directions: req=0011, dir=0001, count=5 → requester 0 gives count=6 with inc. Requester 1 next gives count=5 with dec.
- Async reset: assert reset in UPDATE's preceding GRANT cycle, between edges → outputs zero at once, count=0, step never applied. Deasserting reset resumes from IDLE.
